// File: rtl/cpu_sequencer_pkg.sv
// Shared codes for the 6502 cycle sequencer: addressing modes, address-bus selects,
// state encoding, the registered output bundle and small decode helpers.
package cpu_sequencer_pkg;

    localparam int STATE_W = 4;
    localparam int ADR_W   = 4;

    localparam logic [ADR_W-1:0] ADR_IMPL  = 4'd0;
    localparam logic [ADR_W-1:0] ADR_IMM   = 4'd1;
    localparam logic [ADR_W-1:0] ADR_ZPG   = 4'd2;
    localparam logic [ADR_W-1:0] ADR_ZPG_I = 4'd3;
    localparam logic [ADR_W-1:0] ADR_ABS   = 4'd4;
    localparam logic [ADR_W-1:0] ADR_ABS_I = 4'd5;
    localparam logic [ADR_W-1:0] ADR_IND   = 4'd6;
    localparam logic [ADR_W-1:0] ADR_X_IND = 4'd7;
    localparam logic [ADR_W-1:0] ADR_IND_Y = 4'd8;
    localparam logic [ADR_W-1:0] ADR_REL   = 4'd9;
    localparam logic [ADR_W-1:0] ADR_INVAL = 4'd15;

    localparam logic [1:0] ADDR_SEL_PC  = 2'd0;
    localparam logic [1:0] ADDR_SEL_ABS = 2'd1;
    localparam logic [1:0] ADDR_SEL_ZP  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        SEQ_FETCH  = 4'd0,
        SEQ_OP1    = 4'd1,
        SEQ_OP2    = 4'd2,
        SEQ_IDX    = 4'd3,
        SEQ_PTRLO  = 4'd4,
        SEQ_PTRHI  = 4'd5,
        SEQ_DATA   = 4'd6,
        SEQ_BRANCH = 4'd7,
        SEQ_FIXUP  = 4'd8,
        SEQ_HALT   = 4'd9
    } seq_state_t;

    typedef struct packed {
        logic [1:0] addr_sel;
        logic       mem_re;
        logic       mem_we;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       pc_rel;
        logic       adl_load;
        logic       adh_load;
        logic       idx_add;
        logic       exec;
        logic       sync;
        logic       halted;
    } seq_out_t;

    // A stalled cycle keeps the bus request alive but must not advance any datapath register.
    function automatic seq_out_t seq_hold(input seq_out_t cur);
        seq_out_t held;
        held          = '0;
        held.addr_sel = cur.addr_sel;
        held.mem_re   = cur.mem_re;
        held.mem_we   = cur.mem_we;
        held.sync     = cur.sync;
        held.halted   = cur.halted;
        return held;
    endfunction

    function automatic seq_state_t seq_op1_next(input logic [ADR_W-1:0] mode, input logic taken);
        seq_state_t nxt;
        case (mode)
            ADR_IMPL, ADR_IMM:           nxt = SEQ_FETCH;
            ADR_REL:                     nxt = taken ? SEQ_BRANCH : SEQ_FETCH;
            ADR_ZPG:                     nxt = SEQ_DATA;
            ADR_ZPG_I, ADR_X_IND:        nxt = SEQ_IDX;
            ADR_IND_Y:                   nxt = SEQ_PTRLO;
            ADR_ABS, ADR_ABS_I, ADR_IND: nxt = SEQ_OP2;
            ADR_INVAL:                   nxt = SEQ_HALT;
            default:                     nxt = SEQ_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Decoder/datapath-facing bundle of the 6502 sequencer; master is the sequencer side,
// slave is the decoder plus register/ALU/address-latch datapath side.
interface cpu_sequencer_if;
    import cpu_sequencer_pkg::*;

    logic             rdy;
    logic [ADR_W-1:0] adr_mode;
    logic             from_mem;
    logic             to_mem;
    logic             branch;
    logic             branch_taken;
    logic             addr_carry;

    logic [1:0]       addr_sel;
    logic             mem_re;
    logic             mem_we;
    logic             ir_load;
    logic             pc_inc;
    logic             pc_load;
    logic             pc_rel;
    logic             adl_load;
    logic             adh_load;
    logic             idx_add;
    logic             exec;
    logic             sync;
    logic             halted;

    modport master (
        input  rdy, adr_mode, from_mem, to_mem, branch, branch_taken, addr_carry,
        output addr_sel, mem_re, mem_we, ir_load, pc_inc, pc_load, pc_rel,
               adl_load, adh_load, idx_add, exec, sync, halted
    );

    modport slave (
        output rdy, adr_mode, from_mem, to_mem, branch, branch_taken, addr_carry,
        input  addr_sel, mem_re, mem_we, ir_load, pc_inc, pc_load, pc_rel,
               adl_load, adh_load, idx_add, exec, sync, halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// 6502 cycle sequencer: one registered FSM producing the per-cycle bus and strobe vector.
// Define CPU_SEQ_PAGE_CROSS_EN to add the page-cross FIXUP cycle; default build ignores addr_carry.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    cpu_sequencer_if.master bus
);

    seq_state_t r_state;
    seq_out_t   r_out;
    logic       w_fix_idx;
    logic       w_fix_br;
    logic       w_taken;
    logic [1:0] w_data_sel;

`ifdef CPU_SEQ_PAGE_CROSS_EN
    assign w_fix_idx = bus.to_mem | bus.addr_carry;
    assign w_fix_br  = bus.addr_carry;
`else
    assign w_fix_idx = 1'b0;
    assign w_fix_br  = 1'b0;
`endif

    assign w_taken    = bus.branch & bus.branch_taken;
    assign w_data_sel = ((bus.adr_mode == ADR_ZPG) || (bus.adr_mode == ADR_ZPG_I)) ? ADDR_SEL_ZP : ADDR_SEL_ABS;

    // Sequencer state and registered outputs; a cycle's strobes appear after the edge that executes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SEQ_FETCH;
            r_out   <= '0;
        end else if (!bus.rdy) begin
            r_out   <= seq_hold(r_out);
        end else begin
            r_out <= '0;
            case (r_state)
                SEQ_FETCH: begin
                    r_out.mem_re  <= 1'b1;
                    r_out.ir_load <= 1'b1;
                    r_out.pc_inc  <= 1'b1;
                    r_out.sync    <= 1'b1;
                    r_state       <= SEQ_OP1;
                end
                SEQ_OP1: begin
                    case (bus.adr_mode)
                        ADR_IMPL: r_out.exec <= 1'b1;
                        ADR_IMM: begin
                            r_out.mem_re <= 1'b1;
                            r_out.pc_inc <= 1'b1;
                            r_out.exec   <= 1'b1;
                        end
                        ADR_REL, ADR_ZPG, ADR_ZPG_I, ADR_X_IND, ADR_IND_Y, ADR_ABS, ADR_ABS_I, ADR_IND: begin
                            r_out.mem_re   <= 1'b1;
                            r_out.adl_load <= 1'b1;
                            r_out.pc_inc   <= 1'b1;
                        end
                        default: r_out.exec <= 1'b0;
                    endcase
                    r_state <= seq_op1_next(bus.adr_mode, w_taken);
                end
                SEQ_OP2: begin
                    r_out.mem_re   <= 1'b1;
                    r_out.adh_load <= 1'b1;
                    r_out.pc_inc   <= 1'b1;
                    if (bus.adr_mode == ADR_ABS_I) begin
                        r_out.idx_add <= 1'b1;
                        r_state       <= w_fix_idx ? SEQ_FIXUP : SEQ_DATA;
                    end else if (bus.adr_mode == ADR_IND) begin
                        r_state <= SEQ_PTRLO;
                    end else begin
                        r_state <= SEQ_DATA;
                    end
                end
                SEQ_IDX: begin
                    r_out.idx_add <= 1'b1;
                    r_state       <= (bus.adr_mode == ADR_X_IND) ? SEQ_PTRLO : SEQ_DATA;
                end
                SEQ_PTRLO: begin
                    r_out.addr_sel <= (bus.adr_mode == ADR_IND) ? ADDR_SEL_ABS : ADDR_SEL_ZP;
                    r_out.mem_re   <= 1'b1;
                    r_out.adl_load <= 1'b1;
                    r_state        <= SEQ_PTRHI;
                end
                // Pointer+1 never carries into ADH; JMP (ind) takes the new PC straight from this read.
                SEQ_PTRHI: begin
                    r_out.addr_sel <= (bus.adr_mode == ADR_IND) ? ADDR_SEL_ABS : ADDR_SEL_ZP;
                    r_out.mem_re   <= 1'b1;
                    r_out.adh_load <= 1'b1;
                    if (bus.adr_mode == ADR_IND) begin
                        r_out.pc_load <= 1'b1;
                        r_state       <= SEQ_FETCH;
                    end else if (bus.adr_mode == ADR_IND_Y) begin
                        r_out.idx_add <= 1'b1;
                        r_state       <= w_fix_idx ? SEQ_FIXUP : SEQ_DATA;
                    end else begin
                        r_state <= SEQ_DATA;
                    end
                end
                SEQ_DATA: begin
                    if (bus.to_mem) begin
                        r_out.addr_sel <= w_data_sel;
                        r_out.mem_we   <= 1'b1;
                        r_out.exec     <= 1'b1;
                    end else if (bus.from_mem) begin
                        r_out.addr_sel <= w_data_sel;
                        r_out.mem_re   <= 1'b1;
                        r_out.exec     <= 1'b1;
                    end else begin
                        r_out.pc_load <= 1'b1;
                    end
                    r_state <= SEQ_FETCH;
                end
                SEQ_BRANCH: begin
                    r_out.pc_rel <= 1'b1;
                    r_state      <= w_fix_br ? SEQ_FIXUP : SEQ_FETCH;
                end
                SEQ_FIXUP: begin
                    r_out.adh_load <= 1'b1;
                    r_state        <= (bus.adr_mode == ADR_REL) ? SEQ_FETCH : SEQ_DATA;
                end
                SEQ_HALT: begin
                    r_out.halted <= 1'b1;
                    r_state      <= SEQ_HALT;
                end
                default: r_state <= SEQ_FETCH;
            endcase
        end
    end

    assign bus.addr_sel = r_out.addr_sel;
    assign bus.mem_re   = r_out.mem_re;
    assign bus.mem_we   = r_out.mem_we;
    assign bus.ir_load  = r_out.ir_load;
    assign bus.pc_inc   = r_out.pc_inc;
    assign bus.pc_load  = r_out.pc_load;
    assign bus.pc_rel   = r_out.pc_rel;
    assign bus.adl_load = r_out.adl_load;
    assign bus.adh_load = r_out.adh_load;
    assign bus.idx_add  = r_out.idx_add;
    assign bus.exec     = r_out.exec;
    assign bus.sync     = r_out.sync;
    assign bus.halted   = r_out.halted;

endmodule
